// File: rtl/lfsr_checker.sv
// Receive-side checker for the x^4+x^3+1 PRBS: self-synchronises to the serial
// stream, declares lock, then flags and counts bit errors with a flywheel predictor.
module lfsr_checker #(
    parameter int LOCK_MATCHES = 8,
    parameter int LOSS_ERRS    = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCK
    } state_t;

    localparam logic [3:0] LOCK_M = 4'(LOCK_MATCHES);
    localparam logic [3:0] LOSS_E = 4'(LOSS_ERRS);

    state_t           state, state_nx;
    logic [3:0]       sr, sr_nx;
    logic [2:0]       fill, fill_nx;
    logic [3:0]       match_cnt, match_nx;
    logic [3:0]       miss_run, miss_nx;
    logic             locked_nx, err_nx;
    logic [CNT_W-1:0] cnt_nx;

    logic             pred, hit;
    logic [3:0]       sr_din, match_inc, miss_inc;

    // b[n] = b[n-4] ^ b[n-3]; sr[3] is the oldest accepted bit.
    assign pred      = sr[3] ^ sr[2];
    assign hit       = (din == pred);
    assign sr_din    = {sr[2:0], din};
    assign match_inc = match_cnt + 4'd1;
    assign miss_inc  = miss_run + 4'd1;

    // NOTE: every output of this block gets a default first, so no path can leave a
    // signal unassigned and infer a latch; blocking assignments are correct here.
    always_comb begin
        state_nx  = state;
        sr_nx     = sr;
        fill_nx   = fill;
        match_nx  = match_cnt;
        miss_nx   = miss_run;
        locked_nx = locked;
        err_nx    = 1'b0;
        cnt_nx    = err_count;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    sr_nx   = sr_din;
                    fill_nx = (fill == 3'd4) ? fill : fill + 3'd1;
                    // An all-zero window is the LFSR lock-up state and can never predict.
                    if (fill_nx == 3'd4 && sr_din != 4'd0) state_nx = CHECK;
                end
                CHECK: begin
                    sr_nx = sr_din;
                    if (hit) begin
                        if (match_inc == LOCK_M) begin
                            state_nx  = LOCK;
                            locked_nx = 1'b1;
                            match_nx  = 4'd0;
                            miss_nx   = 4'd0;
                        end else begin
                            match_nx = match_inc;
                        end
                    end else begin
                        state_nx = HUNT;
                        fill_nx  = 3'd1;
                        match_nx = 4'd0;
                    end
                end
                LOCK: begin
                    // Flywheel: feed back the prediction so a corrupted bit never enters sr.
                    sr_nx = {sr[2:0], pred};
                    if (hit) begin
                        miss_nx = 4'd0;
                    end else begin
                        err_nx = 1'b1;
                        if (err_count != {CNT_W{1'b1}}) cnt_nx = err_count + CNT_W'(1);
                        if (miss_inc == LOSS_E) begin
                            state_nx  = HUNT;
                            locked_nx = 1'b0;
                            fill_nx   = 3'd0;
                            match_nx  = 4'd0;
                            miss_nx   = 4'd0;
                        end else begin
                            miss_nx = miss_inc;
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end

        if (clear_cnt) cnt_nx = '0;
    end

    // NOTE: state registers use non-blocking assignments and all of them reset, since
    // this is a small control block with no memory arrays.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            sr        <= 4'd0;
            fill      <= 3'd0;
            match_cnt <= 4'd0;
            miss_run  <= 4'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            fill      <= fill_nx;
            match_cnt <= match_nx;
            miss_run  <= miss_nx;
            locked    <= locked_nx;
            err       <= err_nx;
            err_count <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a history-based reference model predicts every
// cycle's outputs for a default instance and a 2-bit-counter instance.
module tb_lfsr_checker;

    localparam int LOCK_N = 8;
    localparam int LOSS_N = 3;

    logic       clk;
    logic       rst;
    logic       din_valid;
    logic       din;
    logic       clear_cnt;
    logic       locked, err;
    logic [7:0] err_count;
    logic       locked2, err2;
    logic [1:0] err_count2;

    lfsr_checker dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    lfsr_checker #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clear_cnt (clear_cnt),
        .locked    (locked2),
        .err       (err2),
        .err_count (err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Aligned PRBS stream from seed 0001, period 15.
    bit seq [15] = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    int ph;

    // Reference model: last four accepted bits plus run counters.
    bit m_hist[$];
    int m_have, m_good, m_bad, m_cnt, m_cnt2;
    bit m_locked, m_err;

    function automatic void model_reset();
        m_hist   = '{0, 0, 0, 0};
        m_have   = 0;
        m_good   = 0;
        m_bad    = 0;
        m_cnt    = 0;
        m_cnt2   = 0;
        m_locked = 0;
        m_err    = 0;
    endfunction

    function automatic void model_step(input bit v, input bit d, input bit c);
        bit pred;
        bit win_nz;
        m_err = 0;
        if (v) begin
            pred   = m_hist[0] ^ m_hist[1];
            win_nz = m_hist[0] | m_hist[1] | m_hist[2] | m_hist[3];
            if (m_locked) begin
                m_hist.push_back(pred);
                if (d != pred) begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                    m_bad++;
                    if (m_bad == LOSS_N) begin
                        m_locked = 0;
                        m_have   = 0;
                        m_good   = 0;
                        m_bad    = 0;
                    end
                end else begin
                    m_bad = 0;
                end
            end else begin
                m_hist.push_back(d);
                if (m_have >= 4 && win_nz) begin
                    if (d == pred) begin
                        m_good++;
                        if (m_good == LOCK_N) begin
                            m_locked = 1;
                            m_good   = 0;
                            m_bad    = 0;
                        end
                    end else begin
                        m_have = 1;
                        m_good = 0;
                    end
                end else begin
                    m_have = (m_have < 4) ? m_have + 1 : 4;
                end
            end
            void'(m_hist.pop_front());
        end
        if (c) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end
    endfunction

    typedef struct {
        bit locked;
        bit err;
        int cnt;
        int cnt2;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Monitor: compares the outputs left by the previous rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("locked",     int'(locked),     int'(mon_e.locked));
            check("err",        int'(err),        int'(mon_e.err));
            check("err_count",  int'(err_count),  mon_e.cnt);
            check("locked_w2",  int'(locked2),    int'(mon_e.locked));
            check("err_w2",     int'(err2),       int'(mon_e.err));
            check("err_count2", int'(err_count2), mon_e.cnt2);
        end
    end

    task automatic drive(input logic v, input logic d, input logic c);
        exp_t e;
        din_valid = v;
        din       = d;
        clear_cnt = c;
        @(posedge clk);
        #1;
        model_step(v, d, c);
        e.locked = m_locked;
        e.err    = m_err;
        e.cnt    = m_cnt;
        e.cnt2   = m_cnt2;
        exp_q.push_back(e);
    endtask

    task automatic send(input bit flip, input bit clr);
        drive(1'b1, seq[ph] ^ flip, clr);
        ph = (ph + 1) % 15;
    endtask

    task automatic idle();
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_rst_locked"}, int'(locked), 0);
        check({tag, "_rst_err"}, int'(err), 0);
        check({tag, "_rst_cnt"}, int'(err_count), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ph  = 0;
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 1'b0;
        clear_cnt = 1'b0;
        ph        = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_locked", int'(locked), 0);
        check("reset_err", int'(err), 0);
        check("reset_cnt", int'(err_count), 0);
        @(negedge clk);
        rst = 1'b0;

        // Aligned stream: lock on bit 12, no errors.
        for (int i = 1; i <= 60; i++) begin
            send(1'b0, 1'b0);
            if (i == 11) check("t1_unlocked_bit11", int'(locked), 0);
            if (i == 12) check("t1_locked_bit12", int'(locked), 1);
        end
        check("t1_cnt_after60", int'(err_count), 0);

        // Single flipped bit while locked: one pulse, flywheel keeps following bits clean.
        for (int i = 1; i <= 30; i++) begin
            send(i == 10, 1'b0);
            if (i == 10) begin
                check("t2_err_pulse", int'(err), 1);
                check("t2_cnt", int'(err_count), 1);
                check("t2_still_locked", int'(locked), 1);
            end
            if (i == 11) check("t2_err_drop", int'(err), 0);
        end

        // Three consecutive errors drop lock; re-lock 12 bits later.
        send(1'b0, 1'b1);
        check("t3_clear", int'(err_count), 0);
        repeat (5) send(1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            send(1'b1, 1'b0);
            check("t3_err_pulse", int'(err), 1);
            if (i == 2) check("t3_locked_2nd", int'(locked), 1);
        end
        check("t3_unlocked", int'(locked), 0);
        check("t3_cnt3", int'(err_count), 3);
        for (int i = 1; i <= 12; i++) begin
            send(1'b0, 1'b0);
            if (i == 11) check("t3_relock_pre", int'(locked), 0);
        end
        check("t3_relock", int'(locked), 1);
        check("t3_cnt_held", int'(err_count), 3);

        // Arbitrary phase with gapped valid.
        do_reset("t4");
        ph = 6;
        for (int i = 1; i <= 12; i++) begin
            send(1'b0, 1'b0);
            if (i == 11) check("t4_unlocked", int'(locked), 0);
            if (i == 12) check("t4_locked", int'(locked), 1);
            idle();
            check("t4_idle_err", int'(err), 0);
        end

        // All zeros never leaves HUNT.
        do_reset("t5a");
        repeat (20) drive(1'b1, 1'b0, 1'b0);
        check("t5_zero_unlocked", int'(locked), 0);
        check("t5_zero_cnt", int'(err_count), 0);

        // Five isolated errors: 8-bit counter reads 5, 2-bit counter saturates at 3.
        do_reset("t5b");
        repeat (12) send(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 1'b0);
            send(1'b0, 1'b0);
            send(1'b1, 1'b0);
        end
        check("t5_cnt5", int'(err_count), 5);
        check("t5_sat_w2", int'(err_count2), 3);
        check("t5_err_before_rst", int'(err), 1);

        // Reset mid-lock clears everything at once; aligned stream re-locks at bit 12.
        do_reset("t6");
        for (int i = 1; i <= 12; i++) begin
            send(1'b0, 1'b0);
            if (i == 11) check("t6_unlocked", int'(locked), 0);
        end
        check("t6_relock", int'(locked), 1);

        // Clear in the same cycle as an error.
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        check("t5_clr_err", int'(err), 1);
        check("t5_clr_cnt", int'(err_count), 0);

        // Randomised: garbage prefix, random phase, gaps, sparse errors and clears.
        do_reset("rnd");
        repeat (30) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        ph = $urandom_range(0, 14);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) != 0)
                send($urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0);
            else
                idle();
        end

        @(negedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
